// File: rtl/centroid_div_sched_pkg.sv
// Shared types and helpers for the centroid divider scheduler.
package centroid_div_sched_pkg;

  localparam int DIV_W  = 32;
  localparam int DROP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_X,
    ST_ISSUE_Y,
    ST_WAIT,
    ST_PUBLISH
  } state_e;

  // Clamp a quotient to the largest value representable in cw bits.
  function automatic logic [DIV_W-1:0] sat_to_cw(input logic [DIV_W-1:0] q, input int cw);
    logic [DIV_W-1:0] lim;
    lim = {DIV_W{1'b1}} >> (DIV_W - cw);
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/centroid_div_sched_pending_slot.sv
// One-deep holding slot for a frame that arrives while a run is in progress,
// with a saturating count of frames overwritten before they could start.
module centroid_pending_slot
  import centroid_div_sched_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic              i_take,
  input  logic [DIV_W-1:0]  i_x,
  input  logic [DIV_W-1:0]  i_y,
  input  logic [DIV_W-1:0]  i_cnt,
  output logic              o_valid,
  output logic [DIV_W-1:0]  o_x,
  output logic [DIV_W-1:0]  o_y,
  output logic [DIV_W-1:0]  o_cnt,
  output logic [DROP_W-1:0] o_drop_cnt
);

  logic              r_valid;
  logic [DIV_W-1:0]  r_x;
  logic [DIV_W-1:0]  r_y;
  logic [DIV_W-1:0]  r_cnt;
  logic [DROP_W-1:0] r_drop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_drop  <= '0;
    end else begin
      if (i_wr) begin
        r_x   <= i_x;
        r_y   <= i_y;
        r_cnt <= i_cnt;
      end
      if (i_wr)
        r_valid <= 1'b1;
      else if (i_take)
        r_valid <= 1'b0;
      // A write onto a held frame that is not being consumed loses that frame.
      if (i_wr && r_valid && !i_take && (r_drop != {DROP_W{1'b1}}))
        r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign o_valid    = r_valid;
  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_cnt      = r_cnt;
  assign o_drop_cnt = r_drop;

endmodule

// File: rtl/centroid_div_sched.sv
// Shares one pipelined divider between the X and Y centroid divisions.
// Optional build macro CENTROID_SCHED_SMOOTH_EN averages each result with the previous one.
//
// state      | meaning
// IDLE       | waiting for an end-of-frame pulse
// ISSUE_X    | X momentum / count on the divider
// ISSUE_Y    | Y momentum / count on the divider
// WAIT       | quotients in flight, X sampled here
// PUBLISH    | Y quotient sampled, result registered out
module centroid_div_sched
  import centroid_div_sched_pkg::*;
#(
  parameter int DIV_LATENCY = 5,
  parameter int CW          = 12
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iFrameDone,
  input  logic [31:0]   iXSum,
  input  logic [31:0]   iYSum,
  input  logic [31:0]   iCount,
  output logic [31:0]   oDivNumer,
  output logic [31:0]   oDivDenom,
  input  logic [31:0]   iDivQuot,
  output logic [CW-1:0] oXCenter,
  output logic [CW-1:0] oYCenter,
  output logic          oValid,
  output logic          oEmpty,
  output logic          oBusy,
  output logic [7:0]    oDropCnt
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(DIV_LATENCY);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_act_x;
  logic [DIV_W-1:0] r_act_y;
  logic [DIV_W-1:0] r_act_cnt;
  logic [DIV_W-1:0] r_xq;
  logic [CW-1:0]    r_xc;
  logic [CW-1:0]    r_yc;
  logic             r_valid;
  logic             r_empty;

  logic             w_pend_valid;
  logic [DIV_W-1:0] w_pend_x;
  logic [DIV_W-1:0] w_pend_y;
  logic [DIV_W-1:0] w_pend_cnt;
  logic             w_pend_take;
  logic             w_start_new;
  logic             w_slot_wr;
  logic [DIV_W-1:0] w_run_x;
  logic [DIV_W-1:0] w_run_y;
  logic [DIV_W-1:0] w_run_cnt;
  logic             w_act_empty;
  logic [CW-1:0]    w_x_new;
  logic [CW-1:0]    w_y_new;
  logic [CW-1:0]    w_x_pub;
  logic [CW-1:0]    w_y_pub;

  // With nothing held, a frame landing in PUBLISH starts the next run directly.
  assign w_pend_take = (r_state == ST_PUBLISH) && w_pend_valid;
  assign w_start_new = iFrameDone &&
                       ((r_state == ST_IDLE) || ((r_state == ST_PUBLISH) && !w_pend_valid));
  assign w_slot_wr   = iFrameDone && (r_state != ST_IDLE) && !w_start_new;
  assign w_run_x     = w_pend_take ? w_pend_x   : iXSum;
  assign w_run_y     = w_pend_take ? w_pend_y   : iYSum;
  assign w_run_cnt   = w_pend_take ? w_pend_cnt : iCount;

  centroid_pending_slot u_slot (
    .i_clk      (iClk),
    .i_rst_n    (iRstN),
    .i_wr       (w_slot_wr),
    .i_take     (w_pend_take),
    .i_x        (iXSum),
    .i_y        (iYSum),
    .i_cnt      (iCount),
    .o_valid    (w_pend_valid),
    .o_x        (w_pend_x),
    .o_y        (w_pend_y),
    .o_cnt      (w_pend_cnt),
    .o_drop_cnt (oDropCnt)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Y is sampled in PUBLISH itself so the result lands DIV_LATENCY+3 after the pulse.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_new) w_next = (w_run_cnt == '0) ? ST_PUBLISH : ST_ISSUE_X;
      ST_ISSUE_X: w_next = ST_ISSUE_Y;
      ST_ISSUE_Y,
      ST_WAIT:    w_next = (r_cnt == LAT_CNT) ? ST_PUBLISH : ST_WAIT;
      ST_PUBLISH: begin
        if (w_pend_take || w_start_new)
          w_next = (w_run_cnt == '0) ? ST_PUBLISH : ST_ISSUE_X;
        else
          w_next = ST_IDLE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oDivNumer = '0;
    oDivDenom = DIV_W'(1);
    case (r_state)
      ST_ISSUE_X: begin
        oDivNumer = r_act_x;
        oDivDenom = r_act_cnt;
      end
      ST_ISSUE_Y: begin
        oDivNumer = r_act_y;
        oDivDenom = r_act_cnt;
      end
      default: ;
    endcase
  end

  assign oBusy = (r_state != ST_IDLE);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_cnt     <= '0;
      r_act_x   <= '0;
      r_act_y   <= '0;
      r_act_cnt <= '0;
      r_xq      <= '0;
    end else begin
      if (w_next == ST_ISSUE_X)
        r_cnt <= '0;
      else if ((r_state == ST_ISSUE_X) || (r_state == ST_ISSUE_Y) || (r_state == ST_WAIT))
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_start_new || w_pend_take) begin
        r_act_x   <= w_run_x;
        r_act_y   <= w_run_y;
        r_act_cnt <= w_run_cnt;
      end
      if (((r_state == ST_ISSUE_Y) || (r_state == ST_WAIT)) && (r_cnt == LAT_CNT))
        r_xq <= iDivQuot;
    end
  end

  assign w_act_empty = (r_act_cnt == '0);
  assign w_x_new     = CW'(sat_to_cw(r_xq, CW));
  assign w_y_new     = CW'(sat_to_cw(iDivQuot, CW));

`ifdef CENTROID_SCHED_SMOOTH_EN
  logic          r_hist;
  logic [CW:0]   w_x_sum;
  logic [CW:0]   w_y_sum;

  assign w_x_sum = {1'b0, r_xc} + {1'b0, w_x_new} + (CW+1)'(1);
  assign w_y_sum = {1'b0, r_yc} + {1'b0, w_y_new} + (CW+1)'(1);
  assign w_x_pub = r_hist ? CW'(w_x_sum >> 1) : w_x_new;
  assign w_y_pub = r_hist ? CW'(w_y_sum >> 1) : w_y_new;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      r_hist <= 1'b0;
    else if ((r_state == ST_PUBLISH) && !w_act_empty)
      r_hist <= 1'b1;
  end
`else
  assign w_x_pub = w_x_new;
  assign w_y_pub = w_y_new;
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_xc    <= '0;
      r_yc    <= '0;
      r_valid <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_PUBLISH);
      r_empty <= (r_state == ST_PUBLISH) && w_act_empty;
      if ((r_state == ST_PUBLISH) && !w_act_empty) begin
        r_xc <= w_x_pub;
        r_yc <= w_y_pub;
      end
    end
  end

  assign oXCenter = r_xc;
  assign oYCenter = r_yc;
  assign oValid   = r_valid;
  assign oEmpty   = r_empty;

endmodule

// File: tb/tb_centroid_div_sched.sv
// Directed bench for centroid_div_sched with a pipelined divider model and an in-order scoreboard.
module tb_centroid_div_sched;

  localparam int LAT = 5;
  localparam int CW  = 12;
  localparam int SAT = (1 << CW) - 1;

  logic          iClk = 1'b0;
  logic          iRstN = 1'b1;
  logic          iFrameDone = 1'b0;
  logic [31:0]   iXSum = '0;
  logic [31:0]   iYSum = '0;
  logic [31:0]   iCount = '0;
  logic [31:0]   oDivNumer;
  logic [31:0]   oDivDenom;
  logic [31:0]   iDivQuot;
  logic [CW-1:0] oXCenter;
  logic [CW-1:0] oYCenter;
  logic          oValid;
  logic          oEmpty;
  logic          oBusy;
  logic [7:0]    oDropCnt;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct {
    int unsigned x;
    int unsigned y;
    bit          empty;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned m_x = 0;
  int unsigned m_y = 0;
  bit          m_hist = 1'b0;
  logic [31:0] dpipe [LAT];

  centroid_div_sched #(.DIV_LATENCY(LAT), .CW(CW)) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iFrameDone (iFrameDone),
    .iXSum      (iXSum),
    .iYSum      (iYSum),
    .iCount     (iCount),
    .oDivNumer  (oDivNumer),
    .oDivDenom  (oDivDenom),
    .iDivQuot   (iDivQuot),
    .oXCenter   (oXCenter),
    .oYCenter   (oYCenter),
    .oValid     (oValid),
    .oEmpty     (oEmpty),
    .oBusy      (oBusy),
    .oDropCnt   (oDropCnt)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // External divider: quotient appears LAT cycles after the operands are driven; not reset.
  always @(posedge iClk) begin
    dpipe[0] <= (oDivDenom == 32'd0) ? 32'hFFFF_FFFF : oDivNumer / oDivDenom;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign iDivQuot = dpipe[LAT-1];

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_total++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned sat_m(input int unsigned v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic push_exp(input int unsigned x, input int unsigned y,
                          input int unsigned cnt, input int due);
    exp_t e;
    int unsigned nx;
    int unsigned ny;
    if (cnt == 0) begin
      e.x = m_x;
      e.y = m_y;
      e.empty = 1'b1;
    end else begin
      nx = sat_m(x / cnt);
      ny = sat_m(y / cnt);
`ifdef CENTROID_SCHED_SMOOTH_EN
      if (m_hist) begin
        nx = (m_x + nx + 1) / 2;
        ny = (m_y + ny + 1) / 2;
      end
      m_hist = 1'b1;
`endif
      m_x = nx;
      m_y = ny;
      e.x = nx;
      e.y = ny;
      e.empty = 1'b0;
    end
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic drive(input int unsigned x, input int unsigned y, input int unsigned cnt);
    iXSum = x;
    iYSum = y;
    iCount = cnt;
    iFrameDone = 1'b1;
    @(posedge iClk);
    #1;
    iFrameDone = 1'b0;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) begin
      @(posedge iClk);
      #1;
    end
  endtask

  always @(negedge iClk) begin : monitor
    if (iRstN && oValid) begin
      if (sb.size() == 0) begin
        chk("valid_without_expect", oValid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("pub_x", oXCenter, mon_e.x);
        chk("pub_y", oYCenter, mon_e.y);
        chk("pub_empty", oEmpty, mon_e.empty);
        chk("pub_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    int t;
    #2 iRstN = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_xc", oXCenter, 0);
    chk("rst_yc", oYCenter, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_empty", oEmpty, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_drop", oDropCnt, 0);
    chk("rst_numer", oDivNumer, 0);
    chk("rst_denom", oDivDenom, 1);
    iRstN = 1'b1;
    go_to(cyc + 2);

    // Basic frame and divider drive sequence
    t = cyc;
    push_exp(6400, 3200, 64, t + LAT + 3);
    drive(6400, 3200, 64);
    @(negedge iClk);
    chk("issue_x_numer", oDivNumer, 6400);
    chk("issue_x_denom", oDivDenom, 64);
    @(negedge iClk);
    chk("issue_y_numer", oDivNumer, 3200);
    chk("issue_y_denom", oDivDenom, 64);
    @(negedge iClk);
    chk("idle_numer", oDivNumer, 0);
    chk("idle_denom", oDivDenom, 1);
    go_to(t + 12);

    // Empty frame: no divider use, centers held
    t = cyc;
    push_exp(123, 456, 0, t + 2);
    drive(123, 456, 0);
    @(negedge iClk);
    chk("empty_numer", oDivNumer, 0);
    chk("empty_denom", oDivDenom, 1);
    chk("empty_busy", oBusy, 1);
    go_to(t + 6);

    // Saturation
    t = cyc;
    push_exp(10000000, 20, 1, t + LAT + 3);
    drive(10000000, 20, 1);
    go_to(t + 12);

    t = cyc;
    push_exp(5000, 2331, 3, t + LAT + 3);
    drive(5000, 2331, 3);
    go_to(t + 12);
    chk("idle_after_run", oBusy, 0);

    // A, then B 3 cycles in, then C 2 cycles later: B is overwritten
    t = cyc;
    push_exp(640, 1280, 10, t + LAT + 3);
    drive(640, 1280, 10);
    go_to(t + 3);
    drive(1, 1, 1);
    go_to(t + 5);
    push_exp(300, 900, 3, t + 2 * (LAT + 3) - 1);
    drive(300, 900, 3);
    @(negedge iClk);
    chk("drop_after_c", oDropCnt, 1);
    go_to(t + LAT + 3);
    @(negedge iClk);
    chk("c_no_gap_busy", oBusy, 1);
    chk("c_issue_numer", oDivNumer, 300);
    chk("c_issue_denom", oDivDenom, 3);
    go_to(t + 24);
    chk("drop_hold", oDropCnt, 1);

    // Pending empty frame published straight after the running one
    t = cyc;
    push_exp(800, 400, 8, t + LAT + 3);
    drive(800, 400, 8);
    go_to(t + 2);
    push_exp(7, 7, 0, t + LAT + 4);
    drive(7, 7, 0);
    go_to(t + 14);

    // Reset during WAIT aborts the run; pipe contents must not publish
    t = cyc;
    drive(500, 1000, 5);
    go_to(t + 4);
    chk("wait_busy", oBusy, 1);
    iRstN = 1'b0;
    #1;
    chk("arst_xc", oXCenter, 0);
    chk("arst_yc", oYCenter, 0);
    chk("arst_valid", oValid, 0);
    chk("arst_busy", oBusy, 0);
    chk("arst_drop", oDropCnt, 0);
    chk("arst_numer", oDivNumer, 0);
    chk("arst_denom", oDivDenom, 1);
    m_x = 0;
    m_y = 0;
    m_hist = 1'b0;
    go_to(t + 6);
    iRstN = 1'b1;
    go_to(t + 20);

    t = cyc;
    push_exp(200, 300, 2, t + LAT + 3);
    drive(200, 300, 2);
    go_to(t + 14);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/centroid_div_sched.md
Name: centroid_div_sched

Overview:
- Sequencer that shares one external pipelined 32/32 divider between the X and Y centroid divisions of the skin-centroid path.
- On each end-of-frame pulse it snapshots the frame's X-momentum, Y-momentum and pixel count.
- It issues the X division, then the Y division, collects both quotients and publishes a centroid pair with a valid pulse.
- Sits between the momentum accumulators and the overlay/tracking consumers; replaces one of the two dividers.

Parameters:
- DIV_LATENCY, 5: cycles from operands presented to quotient valid on iDivQuot (must be >= 1).
- CW, 12: centroid coordinate width.

Ports:
- iClk  in  1  clock
- iRstN  in  1  asynchronous active-low reset
- iFrameDone  in  1  one-cycle pulse; frame sums below are valid this cycle
- iXSum  in  32  sum of X over skin pixels
- iYSum  in  32  sum of Y over skin pixels
- iCount  in  32  number of skin pixels
- oDivNumer  out  32  divider numerator
- oDivDenom  out  32  divider denominator
- iDivQuot  in  32  divider quotient, DIV_LATENCY cycles after operands
- oXCenter  out  CW  published X centroid
- oYCenter  out  CW  published Y centroid
- oValid  out  1  one-cycle pulse when a result is published
- oEmpty  out  1  qualifies oValid: frame had zero skin pixels
- oBusy  out  1  high whenever state != IDLE
- oDropCnt  out  8  frames lost to pending overwrite, saturating

Behaviour:
- Reset (async assert, sync release) values:
  - oXCenter = oYCenter = 0; oValid = oEmpty = oBusy = 0; oDropCnt = 0.
  - oDivNumer = 0, oDivDenom = 1.
  - State IDLE; pending flag clear.
- Reset mid-operation aborts the run. Quotients already in the divider pipe are ignored after release (the state is IDLE).
- States: IDLE, ISSUE_X, ISSUE_Y, WAIT, PUBLISH.
- IDLE:
  - iFrameDone=1 captures iXSum/iYSum/iCount into the active regs.
  - If captured count==0, go to PUBLISH directly (no divider use). Otherwise go to ISSUE_X.
- ISSUE_X (1 cycle): oDivNumer = active X, oDivDenom = active count.
- ISSUE_Y (1 cycle): oDivNumer = active Y, oDivDenom = active count.
- WAIT:
  - A cycle counter started in ISSUE_X selects capture points.
  - X quotient is sampled DIV_LATENCY cycles after ISSUE_X; Y quotient DIV_LATENCY cycles after ISSUE_Y.
  - Leave WAIT after the Y capture.
- Divider drive outside ISSUE_X/ISSUE_Y: numer 0, denom 1. The divider never sees a zero denominator.
- PUBLISH (1 cycle):
  - oValid=1; oXCenter/oYCenter register the captured quotients.
  - Each quotient saturates to 2^CW-1 if it exceeds that value.
  - Empty frame: centers hold their previous values, oEmpty=1 with oValid. oEmpty=0 otherwise.
  - Next state: ISSUE_X (or PUBLISH again if pending count==0) when pending is set, loading pending into active and clearing pending. Otherwise IDLE.
- Latency: iFrameDone to oValid = DIV_LATENCY+3 cycles (8 at default). Empty frame: 2 cycles.
- iFrameDone while oBusy=1, PUBLISH included: snapshot into pending regs and set pending. If pending was already set, overwrite it and increment oDropCnt (saturate at 255).
- Active regs are never modified during a run.
- Outputs hold between publishes.

Optional Feature:
- Macro CENTROID_SCHED_SMOOTH_EN.
- Defined: published centers = (previous + new + 1) >> 1, computed in CW+1 bits. The first result after reset is published raw. Empty frames do not update the history.
- Undefined: raw saturated quotients are published.
- Latency is identical in both builds.

Decomposition:
- Shared package: state enum; DIV_W=32 constant; saturate-to-CW function.
- One natural sub-module, centroid_pending_slot: pending snapshot register, pending flag and the saturating drop counter.
- FSM, divider drive and capture stay in the top.

Test Plan:
- Single frame, X=6400, Y=3200, count=64, model DIV_LATENCY=5:
  - numer 6400 then 3200 on consecutive cycles, denom 64 both.
  - oValid 8 cycles after iFrameDone; X=100, Y=50; oEmpty=0.
- count=0 with stale centers 100/50: no divider issue; oValid+oEmpty after 2 cycles; centers stay 100/50.
- Saturation: X=10,000,000, count=1: oXCenter=4095.
- Frame B arriving 3 cycles into frame A's run, then frame C 2 cycles later:
  - A published, then C published with no IDLE gap; B lost; oDropCnt=1.
- Reset asserted during WAIT: outputs 0 immediately; no oValid after release despite quotients still in the pipe.
- With CENTROID_SCHED_SMOOTH_EN: frames giving X=100 then X=201 publish 100 then 151.
